// File: rtl/sliced_logic_unit.sv
// Multi-cycle bitwise logic unit: applies AND/OR/XOR/NOR to two WIDTH-bit
// operands, SLICE bits per clock, LSB slice first. Operands arrive on a
// valid/ready handshake. The result is held on a valid/ready output until the
// consumer takes it.
module sliced_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] leftOperand,
  input  logic [WIDTH-1:0] rightOperand,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             allOnes
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  // The slice arithmetic assumes the operand splits evenly into slices.
  if ((WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("sliced_logic_unit: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_t;

  state_t state, state_next;

  // Latched operand bundle. The operand registers shift right by one slice per
  // BUSY cycle, so the slice being processed is always in the low bits and no
  // wide read multiplexer is needed.
  logic [WIDTH-1:0] lhs_q, rhs_q;
  op_t              op_q;
  logic [CNT_W-1:0] cnt;

  logic [SLICE-1:0] slice_res;
  logic [WIDTH-1:0] slice_mask;
  logic [WIDTH-1:0] result_next;
  logic             last_slice;

  // Applies the selected bitwise operation to one slice.
  function automatic logic [SLICE-1:0] apply_op(input op_t f,
                                                input logic [SLICE-1:0] a,
                                                input logic [SLICE-1:0] b);
    logic [SLICE-1:0] r;
    case (f)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~(a | b);
    endcase
    return r;
  endfunction

  // The unit takes a new bundle only while idle, and never during reset.
  assign in_ready   = (state == IDLE) && !rst;
  assign last_slice = (cnt == LAST_SLICE);

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments (<=) so
  // that every flop samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: accept -> compute NSLICE slices -> hold until consumed.
  // NOTE: state_next gets a default before the case so that no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = BUSY;
      BUSY:    if (last_slice) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Computes this cycle's slice and merges it into the result at slot cnt.
  always_comb begin
    slice_res   = apply_op(op_q, lhs_q[SLICE-1:0], rhs_q[SLICE-1:0]);
    slice_mask  = WIDTH'({SLICE{1'b1}}) << (int'(cnt) * SLICE);
    result_next = (result & ~slice_mask)
                | (WIDTH'(slice_res) << (int'(cnt) * SLICE));
  end

  // Datapath: operand capture, per-slice result update and the output flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      lhs_q     <= '0;
      rhs_q     <= '0;
      op_q      <= OP_AND;
      cnt       <= '0;
      result    <= '0;
      zero      <= 1'b0;
      allOnes   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            lhs_q  <= leftOperand;
            rhs_q  <= rightOperand;
            op_q   <= op_t'(op);
            cnt    <= '0;
            result <= '0;
          end
        end
        BUSY: begin
          result <= result_next;
          lhs_q  <= lhs_q >> SLICE;
          rhs_q  <= rhs_q >> SLICE;
          if (last_slice) begin
            // The flags come from the complete result so they are ready
            // together with out_valid.
            cnt       <= '0;
            out_valid <= 1'b1;
            zero      <= (result_next == '0);
            allOnes   <= (&result_next);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            zero      <= 1'b0;
            allOnes   <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // The unit is never ready for input while it still holds a result.
  a_ready_valid_exclusive : assert property (
    @(posedge clk) disable iff (rst) !(in_ready && out_valid));

  // A result that is not yet consumed stays valid and unchanged.
  a_hold_under_backpressure : assert property (
    @(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(result)));

endmodule

// File: tb/tb_sliced_logic_unit.sv
// Self-checking bench for sliced_logic_unit: three instances (32/8, 32/32,
// 64/16) driven by directed steps, with expected results pushed to a
// scoreboard at issue time and popped when out_valid appears.
module tb_sliced_logic_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: WIDTH 32, SLICE 8
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_zero, a_ones;
  logic [31:0] a_l, a_r, a_res;
  logic [1:0]  a_op;
  // Instance B: WIDTH 32, SLICE 32
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_zero, b_ones;
  logic [31:0] b_l, b_r, b_res;
  logic [1:0]  b_op;
  // Instance C: WIDTH 64, SLICE 16
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_zero, c_ones;
  logic [63:0] c_l, c_r, c_res;
  logic [1:0]  c_op;

  sliced_logic_unit #(.WIDTH(32), .SLICE(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .leftOperand(a_l), .rightOperand(a_r), .op(a_op),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .result(a_res),
    .zero(a_zero), .allOnes(a_ones));

  sliced_logic_unit #(.WIDTH(32), .SLICE(32)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .leftOperand(b_l), .rightOperand(b_r), .op(b_op),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .result(b_res),
    .zero(b_zero), .allOnes(b_ones));

  sliced_logic_unit #(.WIDTH(64), .SLICE(16)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .leftOperand(c_l), .rightOperand(c_r), .op(c_op),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .result(c_res),
    .zero(c_zero), .allOnes(c_ones));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] res;
    logic        zero;
    logic        ones;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t sb_c[$];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: bitwise op masked to w bits, plus the two flags.
  function automatic exp_t model(input logic [63:0] l, input logic [63:0] r,
                                 input logic [1:0] f, input int w);
    exp_t e;
    logic [63:0] m, v;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    case (f)
      2'b00:   v = l & r;
      2'b01:   v = l | r;
      2'b10:   v = l ^ r;
      default: v = ~(l | r);
    endcase
    e.res  = v & m;
    e.zero = (e.res == 64'd0);
    e.ones = (e.res == m);
    return e;
  endfunction

  // Presents one bundle to A, lets it be accepted, then scrambles the inputs.
  task automatic a_issue(input string tag, input logic [31:0] l,
                         input logic [31:0] r, input logic [1:0] f);
    chk1({tag, "_in_ready_before"}, a_in_ready, 1'b1);
    a_l = l; a_r = r; a_op = f; a_in_valid = 1'b1;
    sb_a.push_back(model({32'd0, l}, {32'd0, r}, f, 32));
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_l  = 32'hFFFF_FFFF;
    a_r  = 32'hFFFF_FFFF;
    a_op = f ^ 2'b01;
  endtask

  // Waits (bounded) for A's out_valid, checks latency, then pops and compares.
  task automatic a_wait_valid(input string tag);
    exp_t e;
    int   lat;
    bit   seen;
    lat  = -1;
    seen = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (a_out_valid) begin
        seen = 1'b1;
        lat  = j;
        break;
      end
    end
    chk1({tag, "_seen"}, seen, 1'b1);
    chk_int({tag, "_latency"}, lat, 4);
    chk1({tag, "_sb_nonempty"}, sb_a.size() != 0, 1'b1);
    if (sb_a.size() != 0) begin
      e = sb_a.pop_front();
      chk32({tag, "_result"}, a_res, e.res[31:0]);
      chk1({tag, "_zero"}, a_zero, e.zero);
      chk1({tag, "_allones"}, a_ones, e.ones);
    end
    chk1({tag, "_in_ready_done"}, a_in_ready, 1'b0);
  endtask

  // Consumes A's result and checks the return to IDLE with result held.
  task automatic a_release(input string tag, input logic [31:0] held);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    @(negedge clk);
    chk1({tag, "_out_valid"}, a_out_valid, 1'b0);
    chk1({tag, "_in_ready"}, a_in_ready, 1'b1);
    chk1({tag, "_zero"}, a_zero, 1'b0);
    chk1({tag, "_allones"}, a_ones, 1'b0);
    chk32({tag, "_held"}, a_res, held);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bit   extra;
    int   lat;
    a_in_valid = 0; a_out_ready = 0; a_l = 0; a_r = 0; a_op = 0;
    b_in_valid = 0; b_out_ready = 0; b_l = 0; b_r = 0; b_op = 0;
    c_in_valid = 0; c_out_ready = 0; c_l = 0; c_r = 0; c_op = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("rst_a_out_valid", a_out_valid, 1'b0);
    chk32("rst_a_result", a_res, 32'h0);
    chk1("rst_a_zero", a_zero, 1'b0);
    chk1("rst_a_allones", a_ones, 1'b0);
    chk1("rst_a_in_ready", a_in_ready, 1'b1);
    chk1("rst_b_in_ready", b_in_ready, 1'b1);
    chk1("rst_c_out_valid", c_out_valid, 1'b0);

    // NOR of zeros gives all ones
    a_issue("nor0", 32'h0000_0000, 32'h0000_0000, 2'b11);
    a_wait_valid("nor0");
    a_release("nor0_rel", 32'hFFFF_FFFF);

    // AND to zero, then XOR
    a_issue("and", 32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b00);
    a_wait_valid("and");
    a_release("and_rel", 32'h0000_0000);
    a_issue("xor", 32'h1234_5678, 32'hFFFF_FFFF, 2'b10);
    a_wait_valid("xor");
    chk32("xor_literal", a_res, 32'hEDCB_A987);
    a_release("xor_rel", 32'hEDCB_A987);

    // OR with operands changed after accept
    a_issue("or", 32'h8000_0000, 32'h0000_0001, 2'b01);
    a_wait_valid("or");
    chk32("or_literal", a_res, 32'h8000_0001);
    a_release("or_rel", 32'h8000_0001);

    // Consumer with out_ready tied high sees exactly one valid cycle
    a_out_ready = 1'b1;
    a_issue("tied", 32'hA5A5_A5A5, 32'h0F0F_0F0F, 2'b10);
    a_wait_valid("tied");
    @(negedge clk);
    chk1("tied_one_cycle", a_out_valid, 1'b0);
    chk1("tied_in_ready", a_in_ready, 1'b1);
    a_out_ready = 1'b0;

    // Backpressure with a dropped in_valid pulse
    a_issue("bp", 32'hFFFF_0000, 32'h0000_FFFF, 2'b10);
    a_wait_valid("bp");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        a_in_valid = 1'b1; a_l = 32'h0; a_r = 32'h0; a_op = 2'b00;
      end else begin
        a_in_valid = 1'b0;
      end
      @(negedge clk);
      chk1($sformatf("bp_hold%0d_valid", i), a_out_valid, 1'b1);
      chk32($sformatf("bp_hold%0d_result", i), a_res, 32'hFFFF_FFFF);
      chk1($sformatf("bp_hold%0d_allones", i), a_ones, 1'b1);
      chk1($sformatf("bp_hold%0d_in_ready", i), a_in_ready, 1'b0);
    end
    a_release("bp_rel", 32'hFFFF_FFFF);
    extra = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (a_out_valid) extra = 1'b1;
    end
    chk1("bp_pulse_dropped", extra, 1'b0);
    chk_int("bp_sb_empty", sb_a.size(), 0);

    // Reset after two BUSY edges discards the partial result
    a_issue("rstmid", 32'h1234_5678, 32'h9ABC_DEF0, 2'b01);
    @(posedge clk);
    @(posedge clk); #1;
    chk32("rstmid_partial", a_res, 32'h0000_DEF8);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_a.delete();
    @(negedge clk);
    chk1("rstmid_out_valid", a_out_valid, 1'b0);
    chk32("rstmid_result", a_res, 32'h0);
    chk1("rstmid_in_ready", a_in_ready, 1'b1);
    chk1("rstmid_zero", a_zero, 1'b0);
    extra = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (a_out_valid) extra = 1'b1;
    end
    chk1("rstmid_no_output", extra, 1'b0);
    a_issue("nor_alt", 32'hAAAA_AAAA, 32'h5555_5555, 2'b11);
    a_wait_valid("nor_alt");
    chk1("nor_alt_zero_literal", a_zero, 1'b1);
    a_release("nor_alt_rel", 32'h0000_0000);

    // SLICE == WIDTH: single-cycle BUSY
    chk1("b_in_ready_before", b_in_ready, 1'b1);
    b_l = 32'h0000_FFFF; b_r = 32'h00FF_0000; b_op = 2'b11; b_in_valid = 1'b1;
    sb_b.push_back(model({32'd0, b_l}, {32'd0, b_r}, b_op, 32));
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_l = 32'hFFFF_FFFF; b_r = 32'hFFFF_FFFF;
    lat = -1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (b_out_valid) begin
        lat = j;
        break;
      end
    end
    chk_int("b_latency", lat, 1);
    chk_int("b_sb_size", sb_b.size(), 1);
    e = sb_b.pop_front();
    chk32("b_result", b_res, e.res[31:0]);
    chk32("b_result_literal", b_res, 32'hFF00_0000);
    chk1("b_zero", b_zero, e.zero);
    chk1("b_allones", b_ones, e.ones);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    @(negedge clk);
    chk1("b_rel_out_valid", b_out_valid, 1'b0);
    chk1("b_rel_in_ready", b_in_ready, 1'b1);

    // WIDTH 64, SLICE 16: NOR of zeros
    chk1("c_in_ready_before", c_in_ready, 1'b1);
    c_l = 64'h0; c_r = 64'h0; c_op = 2'b11; c_in_valid = 1'b1;
    sb_c.push_back(model(c_l, c_r, c_op, 64));
    @(posedge clk); #1;
    c_in_valid = 1'b0; c_l = '1; c_r = '1; c_op = 2'b00;
    lat = -1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (c_out_valid) begin
        lat = j;
        break;
      end
    end
    chk_int("c_latency", lat, 4);
    chk_int("c_sb_size", sb_c.size(), 1);
    e = sb_c.pop_front();
    chk64("c_result", c_res, e.res);
    chk64("c_result_literal", c_res, 64'hFFFF_FFFF_FFFF_FFFF);
    chk1("c_allones", c_ones, e.ones);
    chk1("c_zero", c_zero, e.zero);
    c_out_ready = 1'b1;
    @(posedge clk); #1;
    c_out_ready = 1'b0;
    @(negedge clk);
    chk1("c_rel_out_valid", c_out_valid, 1'b0);
    chk1("c_rel_allones", c_ones, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
